// File: rtl/core_pkg.sv
// Shared ARM7 core definitions: FSM encodings, register-file constants and
// condition codes used across the execute blocks.
package core_pkg;

  localparam int REG_IDX_W = 4;

  localparam logic [REG_IDX_W-1:0] LR_INDEX = 4'd14;
  localparam logic [31:0]          PC_AHEAD = 32'd8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LINK,
    S_JUMP,
    S_FLUSH
  } br_state_t;

  typedef enum logic [3:0] {
    CC_EQ, CC_NE, CC_CS, CC_CC, CC_MI, CC_PL, CC_VS, CC_VC,
    CC_HI, CC_LS, CC_GE, CC_LT, CC_GT, CC_LE, CC_AL
  } cond_code_t;

  // Signed word offset to a byte displacement.
  function automatic logic [31:0] word_off_to_bytes(input logic [23:0] off);
    return {{6{off[23]}}, off, 2'b00};
  endfunction

endpackage

// File: rtl/branch_exec_if.sv
// Branch descriptor from the decoder plus the register-file, PC and flush
// handshakes driven by branch_exec.
interface branch_exec_if;
  import core_pkg::*;

  logic                 branch_en;
  logic                 branch_cond;
  logic                 branch_link;
  logic [23:0]          branch_offset;
  logic [31:0]          instr_addr;
  logic                 busy;
  logic                 reg_wr_en;
  logic [REG_IDX_W-1:0] reg_wr_addr;
  logic [31:0]          reg_wr_data;
  logic                 pc_wr_en;
  logic [31:0]          pc_wr_data;
  logic                 flush;
  logic                 fetch_ack;
  logic                 done;
  logic                 taken;
  logic                 overrun;

  modport master (
    output branch_en, branch_cond, branch_link, branch_offset, instr_addr, fetch_ack,
    input  busy, reg_wr_en, reg_wr_addr, reg_wr_data, pc_wr_en, pc_wr_data,
           flush, done, taken, overrun
  );

  modport slave (
    input  branch_en, branch_cond, branch_link, branch_offset, instr_addr, fetch_ack,
    output busy, reg_wr_en, reg_wr_addr, reg_wr_data, pc_wr_en, pc_wr_data,
           flush, done, taken, overrun
  );

endinterface

// File: rtl/branch_exec_target_calc.sv
// Combinational branch target and link-address arithmetic; both wrap
// silently modulo 2^32.
module branch_target_calc
  import core_pkg::*;
(
  input  logic [31:0] i_instr_addr,
  input  logic [23:0] i_offset,
  output logic [31:0] o_target,
  output logic [31:0] o_link
);

  assign o_target = i_instr_addr + PC_AHEAD + word_off_to_bytes(i_offset);
  assign o_link   = i_instr_addr + 32'd4;

endmodule

// File: rtl/branch_exec.sv
// ARM B/BL execute: writes LR for BL, loads the PC, then holds flush until
// fetch acknowledges.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | waiting for branch_en; not-taken branches retire from here
//   S_LINK  | reg_wr_en strobe writing the link value into r14
//   S_JUMP  | pc_wr_en strobe with the target; flush raised
//   S_FLUSH | flush held until fetch_ack, then done/taken
module branch_exec
  import core_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  branch_exec_if.slave bus
);

  br_state_t            r_state;
  logic [31:0]          r_target;
  logic                 r_reg_wr_en;
  logic [REG_IDX_W-1:0] r_reg_wr_addr;
  logic [31:0]          r_reg_wr_data;
  logic                 r_pc_wr_en;
  logic [31:0]          r_pc_wr_data;
  logic                 r_flush;
  logic                 r_done;
  logic                 r_taken;
  logic                 r_overrun;

  logic [31:0] w_target;
  logic [31:0] w_link;

  branch_target_calc u_calc (
    .i_instr_addr (bus.instr_addr),
    .i_offset     (bus.branch_offset),
    .o_target     (w_target),
    .o_link       (w_link)
  );

  // Strobes are set on the transition into the state that owns them, so each
  // is visible for exactly the one cycle spent in that state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_target      <= '0;
      r_reg_wr_en   <= 1'b0;
      r_reg_wr_addr <= '0;
      r_reg_wr_data <= '0;
      r_pc_wr_en    <= 1'b0;
      r_pc_wr_data  <= '0;
      r_flush       <= 1'b0;
      r_done        <= 1'b0;
      r_taken       <= 1'b0;
      r_overrun     <= 1'b0;
    end else begin
      r_reg_wr_en <= 1'b0;
      r_pc_wr_en  <= 1'b0;
      r_done      <= 1'b0;
      r_taken     <= 1'b0;

      if (bus.branch_en && (r_state != S_IDLE))
        r_overrun <= 1'b1;

      case (r_state)
        S_IDLE: begin
          if (bus.branch_en) begin
            r_target <= w_target;
            if (!bus.branch_cond) begin
              r_done <= 1'b1;
            end else if (bus.branch_link) begin
              r_state       <= S_LINK;
              r_reg_wr_en   <= 1'b1;
              r_reg_wr_addr <= LR_INDEX;
              r_reg_wr_data <= w_link;
            end else begin
              r_state      <= S_JUMP;
              r_pc_wr_en   <= 1'b1;
              r_pc_wr_data <= w_target;
              r_flush      <= 1'b1;
            end
          end
        end
        S_LINK: begin
          r_state      <= S_JUMP;
          r_pc_wr_en   <= 1'b1;
          r_pc_wr_data <= r_target;
          r_flush      <= 1'b1;
        end
        S_JUMP: begin
          r_state <= S_FLUSH;
        end
        S_FLUSH: begin
          if (bus.fetch_ack) begin
            r_state <= S_IDLE;
            r_flush <= 1'b0;
            r_done  <= 1'b1;
            r_taken <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy        = (r_state != S_IDLE);
  assign bus.reg_wr_en   = r_reg_wr_en;
  assign bus.reg_wr_addr = r_reg_wr_addr;
  assign bus.reg_wr_data = r_reg_wr_data;
  assign bus.pc_wr_en    = r_pc_wr_en;
  assign bus.pc_wr_data  = r_pc_wr_data;
  assign bus.flush       = r_flush;
  assign bus.done        = r_done;
  assign bus.taken       = r_taken;
  assign bus.overrun     = r_overrun;

endmodule

// File: tb/tb_branch_exec.sv
// Directed plus randomized bench for branch_exec against a cycle-schedule
// model derived from the branch timing rules.
module tb_branch_exec;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;
  logic exp_ov;

  branch_exec_if bus ();

  branch_exec dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v)
    else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [31:0] model_target(input logic [31:0] addr, input logic [23:0] off);
    longint o;
    longint t;
    o = longint'(off);
    if (off[23]) o = o - 64'sd16777216;
    t = longint'(addr) + 64'sd8 + o * 64'sd4;
    return t[31:0];
  endfunction

  function automatic logic [31:0] model_link(input logic [31:0] addr);
    longint t;
    t = longint'(addr) + 64'sd4;
    return t[31:0];
  endfunction

  task automatic chk_quiet(input string tag);
    chk({tag, "_reg_wr_en"}, 32'(bus.reg_wr_en), 32'd0);
    chk({tag, "_pc_wr_en"},  32'(bus.pc_wr_en),  32'd0);
    chk({tag, "_flush"},     32'(bus.flush),     32'd0);
    chk({tag, "_done"},      32'(bus.done),      32'd0);
    chk({tag, "_taken"},     32'(bus.taken),     32'd0);
    chk({tag, "_busy"},      32'(bus.busy),      32'd0);
    chk({tag, "_overrun"},   32'(bus.overrun),   32'(exp_ov));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk_quiet("idle");
      bus.fetch_ack = 1'($urandom);
    end
  endtask

  // Called at a negedge; returns at the negedge of the done cycle.
  // d = FLUSH cycles with fetch_ack low, inj = cycle in which a second
  // branch_en is pushed while busy (0 = none).
  task automatic run_br(input logic [31:0] addr, input logic [23:0] off,
                        input logic cond, input logic link, input int d, input int inj);
    int j, dn;
    logic e_reg, e_pc, e_fl, e_done, e_busy;
    logic [31:0] tgt, lnk;
    tgt = model_target(addr, off);
    lnk = model_link(addr);
    j   = link ? 2 : 1;
    dn  = cond ? j + 2 + d : 1;
    bus.branch_en     = 1'b1;
    bus.branch_cond   = cond;
    bus.branch_link   = link;
    bus.branch_offset = off;
    bus.instr_addr    = addr;
    bus.fetch_ack     = 1'($urandom);
    @(posedge clk);
    for (int k = 1; k <= dn; k++) begin
      @(negedge clk);
      e_reg  = cond && link && (k == 1);
      e_pc   = cond && (k == j);
      e_fl   = cond && (k >= j) && (k <= j + 1 + d);
      e_done = (k == dn);
      e_busy = cond && (k < dn);
      chk("reg_wr_en", 32'(bus.reg_wr_en), 32'(e_reg));
      chk("pc_wr_en",  32'(bus.pc_wr_en),  32'(e_pc));
      chk("flush",     32'(bus.flush),     32'(e_fl));
      chk("done",      32'(bus.done),      32'(e_done));
      chk("taken",     32'(bus.taken),     32'(e_done && cond));
      chk("busy",      32'(bus.busy),      32'(e_busy));
      chk("overrun",   32'(bus.overrun),   32'(exp_ov));
      if (e_reg) begin
        chk("reg_wr_addr", 32'(bus.reg_wr_addr), 32'd14);
        chk("reg_wr_data", bus.reg_wr_data, lnk);
      end
      if (e_pc) chk("pc_wr_data", bus.pc_wr_data, tgt);
      if (k == dn) begin
        bus.branch_en = 1'b0;
      end else begin
        if (k == inj) begin
          exp_ov            = 1'b1;
          bus.branch_en     = 1'b1;
          bus.branch_cond   = 1'b1;
          bus.branch_link   = 1'($urandom);
          bus.branch_offset = 24'($urandom);
          bus.instr_addr    = $urandom;
        end else begin
          bus.branch_en = 1'b0;
        end
        if (cond && (k >= j + 1) && (k <= j + 1 + d))
          bus.fetch_ack = (k == j + 1 + d);
        else
          bus.fetch_ack = 1'($urandom);
      end
    end
  endtask

  initial begin
    logic [31:0] a;
    logic [23:0] o;
    logic        c, l;
    int          d, inj;

    errors = 0;
    checks = 0;
    exp_ov = 1'b0;
    clk = 1'b0;
    rst_n = 1'b0;
    bus.branch_en = 1'b0;
    bus.branch_cond = 1'b0;
    bus.branch_link = 1'b0;
    bus.branch_offset = '0;
    bus.instr_addr = '0;
    bus.fetch_ack = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_quiet("reset");
    chk("reset_reg_wr_data", bus.reg_wr_data, 32'd0);
    chk("reset_pc_wr_data",  bus.pc_wr_data,  32'd0);
    rst_n = 1'b1;
    idle(1);

    run_br(32'h0000_1000, 24'h000010, 1'b1, 1'b1, 0, 0);
    idle(1);
    run_br(32'h0000_0100, 24'hFFFFFE, 1'b1, 1'b0, 0, 0);
    idle(1);
    run_br(32'h0000_2000, 24'h000005, 1'b0, 1'b0, 0, 0);
    idle(1);
    run_br(32'hFFFF_FFF8, 24'h000001, 1'b1, 1'b0, 5, 0);
    run_br(32'h0000_3000, 24'h000002, 1'b1, 1'b1, 0, 0);
    idle(1);
    run_br(32'h0000_4000, 24'h000020, 1'b1, 1'b0, 3, 4);
    idle(3);

    // Reset landing in the JUMP cycle of a BL.
    bus.branch_en = 1'b1;
    bus.branch_cond = 1'b1;
    bus.branch_link = 1'b1;
    bus.branch_offset = 24'h000008;
    bus.instr_addr = 32'h0000_5000;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_link", 32'(bus.reg_wr_en), 32'd1);
    bus.branch_en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_jump", 32'(bus.pc_wr_en), 32'd1);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    exp_ov = 1'b0;
    chk_quiet("midrst");
    rst_n = 1'b1;
    idle(3);
    run_br(32'h0000_6000, 24'h000004, 1'b1, 1'b1, 1, 0);

    for (int n = 0; n < 40; n++) begin
      a = $urandom;
      o = 24'($urandom);
      c = ($urandom_range(0, 3) != 0);
      l = 1'($urandom);
      d = $urandom_range(0, 3);
      inj = 0;
      if (c && ($urandom_range(0, 3) == 0))
        inj = $urandom_range(1, (l ? 2 : 1) + 1 + d);
      run_br(a, o, c, l, d, inj);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
    end
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/branch_exec.md
Name: branch_exec

Overview:
- Consumer of the decoder's branch interface (branch_en / branch_cond / branch_link / branch_offset); resolves ARM B/BL in the ARM7 core.
- Computes the branch target, writes LR (r14) for BL through the register-file write port, loads the PC, then holds a pipeline flush until fetch acknowledges.
- Sits between the decoder, the register file and the fetch unit.

Parameters:
- LR_INDEX, 4'd14, register-file index written for BL.
- PC_AHEAD, 32'd8, pipeline offset added to the instruction address, per ARM7 semantics.

Ports:
- clk  input  1  core clock
- rst_n  input  1  synchronous, active-low reset
- branch_en  input  1  one-cycle pulse from the decoder; branch descriptor valid
- branch_cond  input  1  1 = condition passed (taken), 0 = not taken
- branch_link  input  1  1 = BL (write LR)
- branch_offset  input  24  signed word offset from the instruction
- instr_addr  input  32  address of the branch instruction; sampled with branch_en
- busy  output  1  high whenever state != IDLE
- reg_wr_en  output  1  register-file write strobe, one cycle
- reg_wr_addr  output  4  register-file write index
- reg_wr_data  output  32  register-file write data
- pc_wr_en  output  1  PC load strobe, one cycle
- pc_wr_data  output  32  new PC value
- flush  output  1  pipeline flush request, level
- fetch_ack  input  1  fetch unit has discarded the prefetched instructions
- done  output  1  one-cycle completion pulse
- taken  output  1  valid with done; 1 = branch taken
- overrun  output  1  sticky; branch_en arrived while busy

Behaviour:
- Reset is synchronous when rst_n=0 at the clk edge.
  - Every output resets to 0. State resets to IDLE. Latched registers are cleared.
  - Reset in any state aborts the operation. No done pulse. flush drops the next cycle.
- Target arithmetic:
  - target = instr_addr + PC_AHEAD + (sign_extend_32(branch_offset) << 2), modulo 2^32. Wrap-around is silent.
  - link = instr_addr + 4, modulo 2^32.
  - Both are computed from values latched in IDLE.
- States:
  - IDLE: on branch_en, latch cond, link, target and link value.
    - If cond = 0: stay in IDLE. Next cycle done=1 and taken=0. Nothing else is asserted (latency 1).
    - If cond = 1 and link = 1: go to LINK.
    - If cond = 1 and link = 0: go to JUMP.
  - LINK: reg_wr_en=1, reg_wr_addr=LR_INDEX, reg_wr_data=link value. Go to JUMP.
  - JUMP: pc_wr_en=1, pc_wr_data=target, flush=1. Go to FLUSH.
  - FLUSH: flush held at 1 until fetch_ack is sampled at 1.
    - That cycle: go to IDLE.
    - Next cycle: flush=0, done=1, taken=1.
- Latency from the branch_en cycle to the done cycle, with fetch_ack high on its first FLUSH cycle:
  - B: 3 cycles.
  - BL: 4 cycles.
- fetch_ack outside FLUSH is ignored.
- fetch_ack already high on entry to FLUSH completes in a single FLUSH cycle.
- busy is combinational from state: 1 in LINK, JUMP and FLUSH.
- branch_en while busy:
  - Descriptor is dropped and overrun is set. overrun is cleared only by reset.
  - The operation in flight is unaffected.
- branch_en in IDLE on the same cycle that done is pulsing is accepted normally.
- Every strobe is a registered output. Each is high for exactly one cycle per event. reg_wr_en and pc_wr_en are never high in the same cycle.

Decomposition:
- Shared package core_pkg:
  - State encoding: IDLE, LINK, JUMP, FLUSH.
  - LR_INDEX and PC_AHEAD constants.
  - Register index width, 4.
- The condition-code defines (EQ..AL) already belong there. This block does not need them.
- One natural sub-module: branch_target_calc. It is combinational, takes instr_addr and offset, and returns target and link.

Test Plan:
- BL: instr_addr=0x0000_1000, offset=0x000010, cond=1, link=1, fetch_ack tied high.
  - LINK: reg_wr_en with addr=14, data=0x0000_1004.
  - JUMP: pc_wr_data=0x0000_1048.
  - done with taken=1 four cycles after branch_en.
- B backward: instr_addr=0x0000_0100, offset=0xFFFFFE (-2), link=0.
  - No reg_wr_en. pc_wr_data=0x0000_0100. done after 3 cycles.
- Not taken: cond=0, offset=0x000005.
  - No reg_wr_en, pc_wr_en or flush. done=1 with taken=0 one cycle later.
- Wrap and flush stall: instr_addr=0xFFFF_FFF8, offset=0x000001.
  - pc_wr_data=0x0000_0004.
  - fetch_ack held low for 5 cycles: flush stays high throughout. done arrives the cycle after fetch_ack.
- Overrun: second branch_en during FLUSH.
  - overrun=1 and stays 1. The first branch completes unchanged. The second produces no done.
- Reset mid-BL: rst_n=0 in the JUMP cycle.
  - All outputs are 0 the next cycle. No done. A fresh branch after reset completes normally.
